// File: rtl/instr_encoder_pkg.sv
// ---------------------------------------------------------------------------
// instr_encoder_pkg
// Shared constants and types for the RV32I instruction encoder:
//   - major opcodes and the funct3 values that select the shift-immediate form
//   - the canonical NOP word emitted for unsupported opcodes
//   - the instruction format enumeration and the opcode -> format decoder
//   - the 64-bit FIFO word {instruction, address}
// ---------------------------------------------------------------------------
package instr_encoder_pkg;

  localparam logic [6:0] OPC_LOAD   = 7'b000_0011;
  localparam logic [6:0] OPC_OP_IMM = 7'b001_0011;
  localparam logic [6:0] OPC_AUIPC  = 7'b001_0111;
  localparam logic [6:0] OPC_STORE  = 7'b010_0011;
  localparam logic [6:0] OPC_OP     = 7'b011_0011;
  localparam logic [6:0] OPC_LUI    = 7'b011_0111;
  localparam logic [6:0] OPC_BRANCH = 7'b110_0011;
  localparam logic [6:0] OPC_JALR   = 7'b110_0111;
  localparam logic [6:0] OPC_JAL    = 7'b110_1111;

  // OP-IMM funct3 values that carry a shift amount instead of a 12-bit immediate
  localparam logic [2:0] F3_SLLI    = 3'b001;
  localparam logic [2:0] F3_SRLI    = 3'b101;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [2:0] {
    FMT_R,
    FMT_I,
    FMT_SH,
    FMT_S,
    FMT_B,
    FMT_U,
    FMT_J,
    FMT_BAD
  } fmt_e;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] addr;
  } enc_word_t;

  function automatic fmt_e fmt_of(input logic [6:0] opcode, input logic [2:0] funct3);
    fmt_e fmt;
    case (opcode)
      OPC_OP:               fmt = FMT_R;
      OPC_OP_IMM:           fmt = (funct3 == F3_SLLI || funct3 == F3_SRLI) ? FMT_SH : FMT_I;
      OPC_LOAD, OPC_JALR:   fmt = FMT_I;
      OPC_STORE:            fmt = FMT_S;
      OPC_BRANCH:           fmt = FMT_B;
      OPC_LUI, OPC_AUIPC:   fmt = FMT_U;
      OPC_JAL:              fmt = FMT_J;
      default:              fmt = FMT_BAD;
    endcase
    return fmt;
  endfunction

endpackage

// File: rtl/instr_encoder_if.sv
// ---------------------------------------------------------------------------
// instr_encoder_if
// Field-bundle input handshake and encoded-word output handshake.
//   master : producer of bundles / consumer of words (drives in_*, fields, out_ready)
//   slave  : the encoder (drives in_ready, out_valid, out_instr, out_addr)
// ---------------------------------------------------------------------------
interface instr_encoder_if;
  logic        in_valid;
  logic        in_ready;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [4:0]  rd;
  logic [31:0] imm;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_addr;

  modport master (
    output in_valid, opcode, funct3, funct7, rs1, rs2, rd, imm, out_ready,
    input  in_ready, out_valid, out_instr, out_addr
  );

  modport slave (
    input  in_valid, opcode, funct3, funct7, rs1, rs2, rd, imm, out_ready,
    output in_ready, out_valid, out_instr, out_addr
  );
endinterface

// File: rtl/instr_fifo2.sv
// ---------------------------------------------------------------------------
// instr_fifo2
// Two-entry FIFO of {instruction, address} words.
//   clk, rst    : clock, synchronous active-high reset (empties the FIFO)
//   push        : write push_data (ignored when full, even if popping)
//   push_data   : 64-bit word
//   full        : occupancy == 2 (purely registered)
//   pop         : consumer takes head (ignored when empty)
//   valid, head : head word present / head word (zero when empty)
// ---------------------------------------------------------------------------
module instr_fifo2
  import instr_encoder_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  input  logic      push,
  input  enc_word_t push_data,
  output logic      full,
  input  logic      pop,
  output logic      valid,
  output enc_word_t head
);

  enc_word_t  mem [2];
  logic       wr_ptr;
  logic       rd_ptr;
  logic [1:0] count;
  logic       do_push;
  logic       do_pop;

  // Full is judged on the registered count, so a same-cycle pop never
  // frees a slot for a push.
  assign do_push = push & (count != 2'd2);
  assign do_pop  = pop  & (count != 2'd0);

  // NOTE: storage has no reset; emptiness is tracked by count alone and the
  // head is forced to zero when empty, so stale contents are never visible.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (do_push) wr_ptr <= ~wr_ptr;
      if (do_pop)  rd_ptr <= ~rd_ptr;
      case ({do_push, do_pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  assign full  = (count == 2'd2);
  assign valid = (count != 2'd0);
  assign head  = valid ? mem[rd_ptr] : '0;

endmodule

// File: rtl/instr_encoder.sv
// ---------------------------------------------------------------------------
// instr_encoder
// Packs RV32I instruction fields into a 32-bit instruction word, tags it with
// a running address and buffers it in a 2-entry FIFO.
//   clk, rst   : clock, synchronous active-high reset
//   bus        : instr_encoder_if.slave (field bundle in, encoded word out)
//   enc_count  : accepted bundles, saturating at 16'hFFFF
//   err_opcode : sticky, an unsupported opcode was accepted (encoded as NOP)
//   err_range  : sticky, an immediate did not fit its field
// Parameters  : BASE_ADDR (first address after reset), ADDR_STEP (increment)
// Build macro : ENC_RANGE_CHECK_EN enables the immediate range check; when
//               undefined err_range is tied low and no check logic exists.
// ---------------------------------------------------------------------------
module instr_encoder
  import instr_encoder_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned ADDR_STEP = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  instr_encoder_if.slave       bus,
  output logic [15:0]          enc_count,
  output logic                 err_opcode,
  output logic                 err_range
);

  fmt_e        fmt;
  logic [31:0] enc_instr;
  logic        accept;
  logic        fifo_full;
  logic [31:0] addr_q;
  logic [15:0] count_q;
  logic        err_op_q;
  enc_word_t   fifo_head;

  assign fmt = fmt_of(bus.opcode, bus.funct3);

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    enc_instr = NOP_INSTR;
    case (fmt)
      FMT_R:  enc_instr = {bus.funct7, bus.rs2, bus.rs1, bus.funct3, bus.rd, bus.opcode};
      FMT_I:  enc_instr = {bus.imm[11:0], bus.rs1, bus.funct3, bus.rd, bus.opcode};
      FMT_SH: enc_instr = {bus.funct7, bus.imm[4:0], bus.rs1, bus.funct3, bus.rd, bus.opcode};
      FMT_S:  enc_instr = {bus.imm[11:5], bus.rs2, bus.rs1, bus.funct3, bus.imm[4:0],
                           bus.opcode};
      FMT_B:  enc_instr = {bus.imm[12], bus.imm[10:5], bus.rs2, bus.rs1, bus.funct3,
                           bus.imm[4:1], bus.imm[11], bus.opcode};
      FMT_U:  enc_instr = {bus.imm[31:12], bus.rd, bus.opcode};
      FMT_J:  enc_instr = {bus.imm[20], bus.imm[10:1], bus.imm[11], bus.imm[19:12], bus.rd,
                           bus.opcode};
      default: enc_instr = NOP_INSTR;
    endcase
  end

  assign bus.in_ready = ~fifo_full;
  assign accept       = bus.in_valid & ~fifo_full;

  instr_fifo2 u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (accept),
    .push_data ('{instr: enc_instr, addr: addr_q}),
    .full      (fifo_full),
    .pop       (bus.out_ready),
    .valid     (bus.out_valid),
    .head      (fifo_head)
  );

  assign bus.out_instr = fifo_head.instr;
  assign bus.out_addr  = fifo_head.addr;

  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q   <= BASE_ADDR;
      count_q  <= 16'd0;
      err_op_q <= 1'b0;
    end else if (accept) begin
      addr_q <= addr_q + 32'(ADDR_STEP);   // wraps modulo 2^32
      if (count_q != 16'hFFFF) count_q <= count_q + 16'd1;
      if (fmt == FMT_BAD) err_op_q <= 1'b1;
    end
  end

  assign enc_count  = count_q;
  assign err_opcode = err_op_q;

`ifdef ENC_RANGE_CHECK_EN
  logic range_bad;
  logic err_rng_q;

  // The word is still encoded from the truncated bits; this only flags it.
  always_comb begin
    range_bad = 1'b0;
    case (fmt)
      FMT_I, FMT_S: range_bad = (bus.imm[31:11] != {21{bus.imm[11]}});
      FMT_B:        range_bad = (bus.imm[31:12] != {20{bus.imm[12]}}) | bus.imm[0];
      FMT_J:        range_bad = (bus.imm[31:20] != {12{bus.imm[20]}}) | bus.imm[0];
      FMT_U:        range_bad = (bus.imm[11:0] != 12'd0);
      FMT_SH:       range_bad = (bus.imm[31:5] != 27'd0);
      default:      range_bad = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst)                         err_rng_q <= 1'b0;
    else if (accept && range_bad)    err_rng_q <= 1'b1;
  end

  assign err_range = err_rng_q;
`else
  assign err_range = 1'b0;
`endif

endmodule

// File: doc/instr_encoder.md
INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 Parameter BASE_ADDR, default 32'h0000_0000, address tagged to the first encoded word after reset.
REQ-002 Parameter ADDR_STEP, default 4, address increment per accepted instruction.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst  in  1  reset, synchronous and active-high.
REQ-005 in_valid  in  1  field bundle valid.
REQ-006 in_ready  out  1  encoder can accept a bundle this cycle.
REQ-007 opcode  in  7; funct3  in  3; funct7  in  7; rs1, rs2, rd  in  5 each; imm  in  32: instruction fields, imm in architectural (unscrambled) form.
REQ-008 out_valid  out  1  encoded word available.
REQ-009 out_ready  in  1  consumer takes word this cycle.
REQ-010 out_instr  out  32  encoded RV32I instruction word.
REQ-011 out_addr  out  32  address tag of out_instr.
REQ-012 enc_count  out  16  number of accepted bundles, saturating at 16'hFFFF.
REQ-013 err_opcode  out  1  sticky: an unsupported opcode was accepted.
REQ-014 err_range  out  1  sticky: an immediate did not fit its field.

Function
REQ-015 Accept when in_valid and in_ready are both high; transfer out when out_valid and out_ready are both high.
REQ-016 Encoding is combinational on the input fields; the result and its address are pushed into a 2-entry output FIFO on accept.
REQ-017 Latency: a bundle accepted in cycle N is presented on out_* in cycle N+1 at the earliest; no input-to-output combinational path.
REQ-018 in_ready = FIFO not full (registered occupancy); no push-when-full, even if a pop happens in the same cycle.
REQ-019 Simultaneous push and pop with occupancy 1 keeps occupancy 1; FIFO order is strictly preserved.
REQ-020 Formats: R {funct7,rs2,rs1,funct3,rd,op}; I for OP-IMM/LOAD/JALR {imm[11:0],rs1,funct3,rd,op}.
REQ-021 OP-IMM shifts (funct3 001/101) {funct7,imm[4:0],rs1,funct3,rd,op}.
REQ-022 S {imm[11:5],rs2,rs1,funct3,imm[4:0],op}; B {imm[12],imm[10:5],rs2,rs1,funct3,imm[4:1],imm[11],op}.
REQ-023 U for LUI/AUIPC {imm[31:12],rd,op}; J {imm[20],imm[10:1],imm[11],imm[19:12],rd,op}.
REQ-024 Any other opcode encodes as NOP 32'h0000_0013 and sets err_opcode.
REQ-025 Address counter starts at BASE_ADDR, advances by ADDR_STEP per accept, and wraps modulo 2^32.
REQ-026 err_opcode and err_range stay high until rst.

Reset
REQ-027 On rst: FIFO emptied (out_valid=0), in_ready=1, address counter=BASE_ADDR, enc_count=0, err_opcode=0, err_range=0, out_instr=0, out_addr=0.
REQ-028 rst asserted mid-transfer discards all buffered words; input presented during rst is not accepted.

Configuration
REQ-029 Macro ENC_RANGE_CHECK_EN defined: err_range is set on accept if the immediate is out of range: I/S imm not a 12-bit sign-extension; B not a 13-bit even sign-extension; J not a 21-bit even sign-extension; U imm[11:0]!=0; shift imm[31:5]!=0.
REQ-030 Out-of-range words are still encoded from the truncated bits.
REQ-031 Macro undefined: err_range tied 0, no check logic.

Structure
REQ-032 Opcode, funct3 and NOP constants live in the shared define header; also add format constants there.
REQ-033 Buffering is a sub-module instr_fifo2 (2-entry, 64-bit data: instruction and address).

Verification
REQ-034 After rst, ADDI x1,x0,5 (op 0010011, f3 000, rd 1, imm 5) -> out_instr 32'h0050_0093, out_addr 0, one cycle after accept.
REQ-035 SW x2,8(x1) (op 0100011, f3 010, rs1 1, rs2 2, imm 8) -> 32'h0020_A423; JAL x1,+2048 -> 32'h0010_00EF.
REQ-036 Hold out_ready=0 and push 3 bundles -> in_ready low after 2 accepts; release -> 3 words in order, addresses 0, 4, 8.
REQ-037 opcode 7'h7F -> out_instr 32'h0000_0013 and err_opcode=1, held until rst.
REQ-038 ADDI x1,x0,imm=2048 -> out_instr 32'h8000_0093; err_range=1 with ENC_RANGE_CHECK_EN and 0 without it.
REQ-039 Assert rst with 2 words buffered -> next cycle out_valid=0, enc_count=0, next word tagged BASE_ADDR.
